dec_syndrome_locate: RTL
========================

Name: dec_syndrome_locate

Overview:
- Decoder front stage of the SECDED path. Sits directly upstream of dec_flip_a_bit.
- Takes a received data word plus its check bits and overall parity bit, and computes the Hamming syndrome.
- Classifies the error (none, single data bit, single check or parity bit, double or uncorrectable) and locates the data column to correct.
- Results are 2-stage pipelined with valid/ready handshake; also keeps saturating error-event counters.

Parameters:
- DATA_WIDTH, 32, data bits per word; legal values 8, 16, 32.
- CHK_WIDTH, derived: 4, 5 or 6 for DATA_WIDTH 8, 16 or 32. Localparam, not overridable.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  stage can accept input.
- in_data  in  DATA_WIDTH  received data bits.
- in_check  in  CHK_WIDTH  received Hamming check bits.
- in_parity  in  1  received overall parity bit.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  DATA_WIDTH  received data, unmodified; feeds dec_flip_a_bit codeword.
- out_col  out  5  index of erroneous data bit; feeds dec_flip_a_bit whichColIsError.
- out_flip  out  1  1 = downstream must use the flipped word; 0 = pass out_data through.
- out_err_single  out  1  single-bit error detected and correctable.
- out_err_double  out  1  uncorrectable error detected.
- cnt_clr  in  1  synchronous clear of both counters.
- cnt_corr  out  16  count of accepted results with out_err_single=1.
- cnt_uncorr  out  16  count of accepted results with out_err_double=1.

Behaviour:
- H matrix: data bit i uses column H_COL[i]. H_COL[i] is the (i+1)-th integer, ascending from 3, that is not a power of 2. For DATA_WIDTH=8 the columns are 3,5,6,7,9,10,11,12. Check bit j uses column 2^j.
- Syndrome: S = XOR over set data bits i of H_COL[i], XOR in_check.
- Parity error: P = XOR of all in_data bits, all in_check bits, and in_parity.
- Classification (S, P):
  - S=0, P=0: no error. flip=0, single=0, double=0.
  - P=1, S matches H_COL[i]: single data error. flip=1, col=i, single=1.
  - P=1, S=0 or S a power of 2: single check/parity-bit error. flip=0, col=0, single=1.
  - P=0, S≠0: double error. flip=0, double=1.
  - P=1, S nonzero, not a power of 2, no matching data column: uncorrectable. flip=0, double=1.
- out_col: 0 whenever flip=0. Upper bits are 0 when DATA_WIDTH<32.
- Pipeline:
  - Stage 1 registers in_data, S and P.
  - Stage 2 registers the classification and out_* signals.
  - Latency is exactly 2 cycles from an accepted input to out_valid when there is no stall.
- Handshake:
  - adv = !out_valid | out_ready. in_ready = adv. Both stages advance only when adv=1.
  - The stage-1 valid bit moves into out_valid on advance.
  - Input is accepted when in_valid & in_ready.
  - While out_valid=1 and out_ready=0, all out_* signals hold stable and in_ready=0.
  - Full throughput of 1 word per cycle when out_ready is held at 1.
- Counters:
  - Increment on an accepted result (out_valid & out_ready) whose corresponding flag is set.
  - Saturate at 16'hFFFF with no wrap.
  - cnt_clr has priority over a same-cycle increment; the counter reads 0 next cycle.
- Reset:
  - All valid bits, out_* registers and counters clear to 0 asynchronously.
  - A word in flight is discarded.
  - in_ready is 1 one cycle after reset is released.
- Data path registers hold their value when not advancing.

Decomposition:
- Package ecc_pkg holds:
  - function chk_width(DATA_WIDTH);
  - function h_col(i) returning the 6-bit H column;
  - typedef err_class_e {ERR_NONE, ERR_DATA1, ERR_CHK1, ERR_DBL}.
- One sub-module: ecc_syndrome_calc. It is combinational and produces S and P from data, check and parity.
- The column search and classification stay in the top module.

Test Plan (DATA_WIDTH=8):
- data=8'h00, check=0, parity=0 → after 2 cycles: out_valid=1, flip=0, single=0, double=0, counters unchanged.
- data=8'h08, check=0, parity=0 (bit 3 flipped; S=7, P=1) → col=3, flip=1, single=1; cnt_corr=1 after accept.
- data=8'h00, check=4'b0001, parity=0 (check-bit error) → flip=0, col=0, single=1; cnt_corr increments.
- data=8'h03, check=0, parity=0 (S=6, P=0) → double=1, flip=0; cnt_uncorr=1. Repeat 65536+ times: cnt_uncorr saturates at 16'hFFFF. Then cnt_clr=1 in the same cycle as an accept → counter reads 0.
- Stream 4 words, then hold out_ready=0 for 3 cycles → out_* signals stable, in_ready=0, no word lost or duplicated; order preserved after out_ready=1.
- Assert rst while 2 words are in flight → out_valid=0 and counters 0 immediately; the next accepted word emerges 2 cycles after acceptance.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared SECDED decode definitions.
// - chk_width(): number of Hamming check bits for a legal data width (8/16/32).
// - h_col():     H-matrix column of data bit i; the (i+1)-th non-power-of-2 from 3 upward.
// - err_class_e: decoded error class carried through the output stage.
package ecc_pkg;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_DATA1,
    ERR_CHK1,
    ERR_DBL
  } err_class_e;

  function automatic int unsigned chk_width(input int unsigned data_width);
    int unsigned w;
    unique case (data_width)
      8:       w = 4;
      16:      w = 5;
      default: w = 6;
    endcase
    return w;
  endfunction

  // Powers of two are reserved for the check-bit columns, so data columns skip them.
  function automatic logic [5:0] h_col(input int unsigned i);
    int unsigned n;
    logic [5:0]  col;
    n   = 0;
    col = '0;
    for (int unsigned v = 3; v < 64; v++) begin
      if ((v & (v - 1)) != 0) begin
        if (n == i) col = 6'(v);
        n++;
      end
    end
    return col;
  endfunction

endpackage

// File: rtl/dec_syndrome_locate_if.sv
// Stream interface of the syndrome/locate stage.
// - in_*:  received word (data, check bits, overall parity) with valid/ready.
// - out_*: unmodified data, error column, flip request and error flags with valid/ready.
// master = upstream/downstream environment side, slave = decoder side.
interface dec_syndrome_locate_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned CHK_WIDTH = ecc_pkg::chk_width(DATA_WIDTH);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic [CHK_WIDTH-1:0]  in_check;
  logic                  in_parity;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [4:0]            out_col;
  logic                  out_flip;
  logic                  out_err_single;
  logic                  out_err_double;

  modport master (
    output in_valid, in_data, in_check, in_parity, out_ready,
    input  in_ready, out_valid, out_data, out_col, out_flip, out_err_single, out_err_double
  );

  modport slave (
    input  in_valid, in_data, in_check, in_parity, out_ready,
    output in_ready, out_valid, out_data, out_col, out_flip, out_err_single, out_err_double
  );

endinterface

// File: rtl/ecc_syndrome_calc.sv
// Combinational Hamming syndrome and overall-parity check.
// - data_i/check_i/parity_i: received word.
// - syn_o:  XOR of the H columns of all set data bits, XOR the received check bits.
// - perr_o: XOR of every received bit; 1 means an odd number of bits flipped.
module ecc_syndrome_calc
  import ecc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CHK_WIDTH  = 6
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [CHK_WIDTH-1:0]  check_i,
  input  logic                  parity_i,
  output logic [CHK_WIDTH-1:0]  syn_o,
  output logic                  perr_o
);

  always_comb begin
    syn_o = check_i;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if (data_i[i]) syn_o = syn_o ^ CHK_WIDTH'(h_col(i));
    end
    perr_o = (^data_i) ^ (^check_i) ^ parity_i;
  end

endmodule

// File: rtl/dec_syndrome_locate.sv
// SECDED decoder front stage: syndrome, error classification and data-column locate.
// - clk/rst:      rising-edge clock, asynchronous active-high reset.
// - bus_io:       input word and classified result, both valid/ready.
// - cnt_clr:      synchronous clear of both counters (wins over an increment).
// - cnt_corr:     saturating count of accepted single-error results.
// - cnt_uncorr:   saturating count of accepted uncorrectable results.
// Stage 1 holds data, syndrome and parity error; stage 2 holds the classification.
// Both stages move together whenever the output is empty or being taken.
module dec_syndrome_locate
  import ecc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  dec_syndrome_locate_if.slave  bus_io,
  input  logic                  cnt_clr,
  output logic [15:0]           cnt_corr,
  output logic [15:0]           cnt_uncorr
);

  localparam int unsigned CHK_WIDTH = chk_width(DATA_WIDTH);

  logic                  adv;
  logic [CHK_WIDTH-1:0]  syn;
  logic                  perr;

  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_data_q,  s1_data_d;
  logic [CHK_WIDTH-1:0]  s1_syn_q,   s1_syn_d;
  logic                  s1_perr_q,  s1_perr_d;

  logic                  hit;
  logic [4:0]            hit_col;
  logic                  syn_pow2;
  err_class_e            cls;

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
  logic [4:0]            out_col_q,   out_col_d;
  err_class_e            class_q,     class_d;

  logic [15:0]           cnt_corr_q,   cnt_corr_d;
  logic [15:0]           cnt_uncorr_q, cnt_uncorr_d;
  logic                  out_accept;

  ecc_syndrome_calc #(
    .DATA_WIDTH (DATA_WIDTH),
    .CHK_WIDTH  (CHK_WIDTH)
  ) u_syndrome_calc (
    .data_i   (bus_io.in_data),
    .check_i  (bus_io.in_check),
    .parity_i (bus_io.in_parity),
    .syn_o    (syn),
    .perr_o   (perr)
  );

  assign adv             = !out_valid_q || bus_io.out_ready;
  assign bus_io.in_ready = adv;

  // Stage 1: capture the word and its syndrome only when a word is actually accepted.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_syn_d   = s1_syn_q;
    s1_perr_d  = s1_perr_q;
    if (adv) begin
      s1_valid_d = bus_io.in_valid;
      if (bus_io.in_valid) begin
        s1_data_d = bus_io.in_data;
        s1_syn_d  = syn;
        s1_perr_d = perr;
      end
    end
  end

  // Column search and classification on the stage-1 registers.
  always_comb begin
    hit     = 1'b0;
    hit_col = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if (6'(s1_syn_q) == h_col(i)) begin
        hit     = 1'b1;
        hit_col = 5'(i);
      end
    end
    // Zero counts as a power of two here: with P=1 that is a flipped overall-parity bit.
    syn_pow2 = (s1_syn_q & (s1_syn_q - CHK_WIDTH'(1))) == '0;

    if (!s1_perr_q) begin
      cls = (s1_syn_q == '0) ? ERR_NONE : ERR_DBL;
    end else if (hit) begin
      cls = ERR_DATA1;
    end else if (syn_pow2) begin
      cls = ERR_CHK1;
    end else begin
      cls = ERR_DBL;
    end
  end

  // Stage 2: result registers.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_col_d   = out_col_q;
    class_d     = class_q;
    if (adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = s1_data_q;
        class_d    = cls;
        out_col_d  = (cls == ERR_DATA1) ? hit_col : 5'd0;
      end
    end
  end

  assign out_accept = out_valid_q && bus_io.out_ready;

  always_comb begin
    cnt_corr_d   = cnt_corr_q;
    cnt_uncorr_d = cnt_uncorr_q;
    if (cnt_clr) begin
      cnt_corr_d   = '0;
      cnt_uncorr_d = '0;
    end else if (out_accept) begin
      if (bus_io.out_err_single && (cnt_corr_q != 16'hFFFF)) cnt_corr_d = cnt_corr_q + 16'd1;
      if (bus_io.out_err_double && (cnt_uncorr_q != 16'hFFFF)) begin
        cnt_uncorr_d = cnt_uncorr_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_data_q    <= '0;
      s1_syn_q     <= '0;
      s1_perr_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_col_q    <= '0;
      class_q      <= ERR_NONE;
      cnt_corr_q   <= '0;
      cnt_uncorr_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_data_q    <= s1_data_d;
      s1_syn_q     <= s1_syn_d;
      s1_perr_q    <= s1_perr_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_col_q    <= out_col_d;
      class_q      <= class_d;
      cnt_corr_q   <= cnt_corr_d;
      cnt_uncorr_q <= cnt_uncorr_d;
    end
  end

  always_comb begin
    bus_io.out_flip       = 1'b0;
    bus_io.out_err_single = 1'b0;
    bus_io.out_err_double = 1'b0;
    unique case (class_q)
      ERR_DATA1: begin
        bus_io.out_flip       = 1'b1;
        bus_io.out_err_single = 1'b1;
      end
      ERR_CHK1:  bus_io.out_err_single = 1'b1;
      ERR_DBL:   bus_io.out_err_double = 1'b1;
      default:   ;
    endcase
  end

  assign bus_io.out_valid = out_valid_q;
  assign bus_io.out_data  = out_data_q;
  assign bus_io.out_col   = out_col_q;
  assign cnt_corr         = cnt_corr_q;
  assign cnt_uncorr       = cnt_uncorr_q;

endmodule
